ring_buffer_replayer: RTL
=========================

# ring_buffer_replayer

Read-side sequencer for `ring_buffer`: accepts loop commands (body length, repeat count) and drives the buffer's restricted random-access read port and read-pointer advance interface. It streams the body entries starting at the buffer's current read pointer, replays the body the requested number of times, then releases the body by advancing the read pointer. It sits between a `ring_buffer` holding an instruction stream and a downstream consumer, such as an FPU sequencer or a loop-replay issue stage.

## Interface
- `Depth`, 32: depth of the attached ring buffer; must match it.
- `IterWidth`, 16: width of the repeat-count field.
- `data_t`, logic: entry type, same as the ring buffer.
- Derived, not overridable: `AddrWidth = cf_math_pkg::idx_width(Depth)`, `StepWidth = cf_math_pkg::idx_width(Depth+1)`.

Ports:
- `clk_i`  in  1  clock; single clock domain, all logic on rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  loop command valid.
- `cmd_ready_o`  out  1  command accepted (high only in IDLE).
- `cmd_len_i`  in  StepWidth  body length in entries, 0..Depth.
- `cmd_iters_i`  in  IterWidth  extra repetitions; total passes = `cmd_iters_i`+1.
- `rptr_i`  in  AddrWidth  buffer `rptr_o`.
- `rvalid_o`  out  1  read request to buffer.
- `rready_i`  in  1  buffer `rready_o`.
- `raddr_o`  out  AddrWidth  read address.
- `rdata_i`  in  data_t  buffer `rdata_o`.
- `advance_o`  out  1  read-pointer advance strobe.
- `step_o`  out  StepWidth  advance amount.
- `out_valid_o`  out  1  output entry valid.
- `out_ready_i`  in  1  downstream ready.
- `out_data_o`  out  data_t  output entry (= `rdata_i`).
- `out_last_o`  out  1  final beat of final pass.
- `flush_i`  in  1  abort current command.
- `busy_o`  out  1  state is BUSY.

## Operation
- FSM with two states, IDLE and BUSY; reset state is IDLE.
- IDLE: `cmd_ready_o`=1.
  - On `cmd_valid_i` with `cmd_len_i`≠0: capture `base`=`rptr_i`, `len`, `iters`; clear `offset` and `pass` counters; set `raddr_q`=`rptr_i`; go to BUSY.
  - On `cmd_valid_i` with `cmd_len_i`=0: the command is consumed and the FSM stays IDLE. No beats are issued and there is no advance.
- BUSY:
  - `rvalid_o`=1; `raddr_o`=`raddr_q`.
  - `out_valid_o`=`rready_i`; `out_data_o`=`rdata_i`.
  - A beat fires when `rready_i` && `out_ready_i`.
- On each beat:
  - `offset`+1.
  - `raddr_q`+1, wrapping from Depth-1 to 0. Wrapping is by explicit compare, so non-power-of-two Depth is supported.
- When `offset`=`len`-1 on a beat:
  - `offset`←0 and `raddr_q`←`base`.
  - `pass`+1.
- Final beat (`offset`=`len`-1 and `pass`=`iters`):
  - `out_last_o`=1, `advance_o`=1, `step_o`=`len`, all in the same cycle.
  - Next state is IDLE.
- `advance_o` is asserted for exactly one cycle per non-empty command. `step_o` is 0 whenever `advance_o`=0.
- `flush_i` in BUSY: go to IDLE next cycle with no further beats and no advance. `flush_i` has priority over a same-cycle beat; that beat counts as not delivered and `advance_o` stays low. In IDLE, `flush_i` has no effect.
- `rvalid_o`/`raddr_o` stay stable while `rready_i`=0, as required by the buffer's stability check. `rvalid_o` is never dropped before a beat except on flush.
- Counter widths:
  - `offset` is StepWidth.
  - `pass` is IterWidth; `iters`=all-ones is legal and must not overflow the compare.
- Illegal input: `cmd_len_i`>Depth. A simulation assertion flags it; the behaviour is undefined.

## Timing
- Reset values of outputs:
  - `cmd_ready_o`=1.
  - 0 for `rvalid_o`, `raddr_o`, `advance_o`, `step_o`, `out_valid_o`, `out_last_o` and `busy_o`.
  - `out_data_o` follows `rdata_i`.
- Command accepted at cycle t: the first read request is at t+1.
- Throughput is one beat per cycle while `rready_i` and `out_ready_i` are both high.
- The final beat and `advance_o` occur in cycle T. The buffer's `rptr` updates at T+1, and the FSM is back in IDLE at T+1. A new command accepted at T+1 samples the updated `rptr_i`, so there is one bubble between commands.
- No combinational path from `out_ready_i` or `rready_i` to `rvalid_o`/`raddr_o`. The path `rready_i` → `out_valid_o` is combinational.
- Async reset mid-command forces IDLE immediately and drops all strobes. No advance is issued.

## Test plan
- Depth=8, buffer holds A..D at 0..3, rptr=0; cmd len=3 iters=0 → out A,B,C; `out_last_o` and `advance_o` with step=3 on C; `cmd_ready_o`=1 next cycle; buffer rptr=3.
- len=2 iters=2 → A,B,A,B,A,B; exactly one advance, step=2, on the sixth beat.
- rptr=6, entries at 6,7,0,1, len=4 iters=1 → raddr sequence 6,7,0,1,6,7,0,1; advance step=4; buffer rptr=2.
- len=3 with only 1 entry written → `rvalid_o`=1, `raddr_o`=1 stable, `out_valid_o`=0 until the writer fills entry 1; then output resumes in order with no lost or duplicated beats.
- `out_ready_i` toggled randomly, len=4 iters=3 → 16 beats in order, `raddr_o` stable during stalls, one advance.
- len=0 → consumed in one cycle, no beats, no advance. `flush_i` at beat 2 of len=4 → IDLE next cycle, no advance, buffer rptr unchanged. Reset mid-command → all outputs at reset values.

Source files
------------

// File: rtl/ring_buffer_replayer.sv
// Read-side loop sequencer for ring_buffer: streams a body of entries from the
// buffer's read pointer, replays it iters+1 times, then releases it with one advance.
module ring_buffer_replayer #(
   parameter  int unsigned Depth     = 32,
   parameter  int unsigned IterWidth = 16,
   parameter  type         data_t    = logic,
   localparam int unsigned AddrWidth = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned StepWidth = (Depth + 1 > 1) ? $clog2(Depth + 1) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [StepWidth-1:0] cmd_len_i,
   input  logic [IterWidth-1:0] cmd_iters_i,
   input  logic [AddrWidth-1:0] rptr_i,
   output logic                 rvalid_o,
   input  logic                 rready_i,
   output logic [AddrWidth-1:0] raddr_o,
   input  data_t                rdata_i,
   output logic                 advance_o,
   output logic [StepWidth-1:0] step_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output data_t                out_data_o,
   output logic                 out_last_o,
   input  logic                 flush_i,
   output logic                 busy_o
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t               state;
   logic [AddrWidth-1:0] base;
   logic [AddrWidth-1:0] raddr_q;
   logic [StepWidth-1:0] len;
   logic [StepWidth-1:0] offset;
   logic [IterWidth-1:0] iters;
   logic [IterWidth-1:0] pass;

   logic busy;
   logic beat;
   logic body_end;
   logic final_beat;

   assign busy       = (state == BUSY);
   assign beat       = busy && rready_i && out_ready_i && !flush_i;
   assign body_end   = (offset == len - StepWidth'(1));
   // pass never increments past iters, so an all-ones iters cannot overflow
   assign final_beat = body_end && (pass == iters);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         base    <= '0;
         raddr_q <= '0;
         len     <= '0;
         offset  <= '0;
         iters   <= '0;
         pass    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid_i && (cmd_len_i != '0)) begin
                  base    <= rptr_i;
                  raddr_q <= rptr_i;
                  len     <= cmd_len_i;
                  iters   <= cmd_iters_i;
                  offset  <= '0;
                  pass    <= '0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (flush_i) begin
                  state <= IDLE;
               end else if (beat) begin
                  if (body_end) begin
                     offset  <= '0;
                     raddr_q <= base;
                     if (final_beat) begin
                        state <= IDLE;
                     end else begin
                        pass <= pass + IterWidth'(1);
                     end
                  end else begin
                     offset  <= offset + StepWidth'(1);
                     raddr_q <= (raddr_q == AddrWidth'(Depth - 1)) ? '0
                                                                   : raddr_q + AddrWidth'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cmd_ready_o = !busy;
   assign busy_o      = busy;
   assign rvalid_o    = busy;
   assign raddr_o     = raddr_q;
   assign out_valid_o = busy && rready_i;
   assign out_data_o  = rdata_i;
   assign out_last_o  = busy && rready_i && final_beat;
   assign advance_o   = beat && final_beat;
   assign step_o      = advance_o ? len : '0;

   cmd_len_in_range: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (cmd_valid_i && !busy) |-> (cmd_len_i <= StepWidth'(Depth))
   );

endmodule
